// File: rtl/fwd_hazard_unit.sv
// Purpose : EX-stage operand forwarding select and load-use hazard control.
// Latency : fwd_a/fwd_b registered, valid in the instruction's EX cycle; stall is combinational.
// Backpressure: stall holds PC/IF-ID for one cycle per load-use; flush overrides stall.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   id_*                - ID-stage instruction metadata (valid, rs, rt, rd, regwrite, memread)
//   flush               - kill the ID instruction, a bubble enters EX
//   stall               - hold PC and IF/ID this cycle
//   fwd_a, fwd_b        - operand mux selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_cnt, fwd_cnt  - saturating statistics, present only with FWD_HAZARD_STATS_EN

module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
`endif
);

    typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

    state_t            state_q, state_d;
    logic              ex_valid_q, ex_valid_d, ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              mem_valid_q, mem_valid_d, mem_regwrite_q, mem_regwrite_d;
    logic              mem_memread_q, mem_memread_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
    logic              wb_memread_q, wb_memread_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    logic ex_wr, mem_wr;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic load_use, advance;

    // A writer only counts if it is real, writes, and does not target r0.
    assign ex_wr     = ex_valid_q && ex_regwrite_q && (ex_rd_q != '0);
    assign mem_wr    = mem_valid_q && mem_regwrite_q && (mem_rd_q != '0);
    assign ex_hit_a  = ex_wr && (ex_rd_q == id_rs);
    assign ex_hit_b  = ex_wr && (ex_rd_q == id_rt);
    assign mem_hit_a = mem_wr && (mem_rd_q == id_rs);
    assign mem_hit_b = mem_wr && (mem_rd_q == id_rt);

    assign load_use = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                      ((ex_rd_q == id_rs) || (ex_rd_q == id_rt));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_use && !flush) begin
                    stall   = 1'b1;
                    state_d = ST_BUBBLE;
                end
            end
            // The load has moved to MEM, so the held instruction picks it up via 01.
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        advance = !stall && !flush;

        ex_valid_d    = advance && id_valid;
        ex_regwrite_d = advance && id_valid && id_regwrite;
        ex_memread_d  = advance && id_valid && id_memread;
        ex_rd_d       = id_rd;

        // Youngest writer (EX) wins over MEM when both match.
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (ex_valid_d) begin
            if (ex_hit_a)       fwd_a_d = 2'b10;
            else if (mem_hit_a) fwd_a_d = 2'b01;
            if (ex_hit_b)       fwd_b_d = 2'b10;
            else if (mem_hit_b) fwd_b_d = 2'b01;
        end

        mem_valid_d    = ex_valid_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_memread_d  = ex_memread_q;
        mem_rd_d       = ex_rd_q;
        wb_valid_d     = mem_valid_q;
        wb_regwrite_d  = mem_regwrite_q;
        wb_memread_d   = mem_memread_q;
        wb_rd_d        = mem_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memread_q   <= 1'b0;
            wb_rd_q        <= '0;
            fwd_a_q        <= 2'b00;
            fwd_b_q        <= 2'b00;
        end else begin
            state_q        <= state_d;
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= mem_valid_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            mem_rd_q       <= mem_rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memread_q   <= wb_memread_d;
            wb_rd_q        <= wb_rd_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

    // WB metadata is tracked but never forwarded: the register file is
    // write-before-read, so an ID read of a WB destination already sees it.
    logic unused_wb;
    assign unused_wb = ^{wb_valid_q, wb_regwrite_q, wb_memread_q, wb_rd_q};

`ifdef FWD_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (advance && ((fwd_a_d != 2'b00) || (fwd_b_d != 2'b00)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose : scoreboard bench for fwd_hazard_unit with a history-based reference model.
// Latency : expects stall in the issue cycle and selects one cycle after issue.
// Backpressure: reissues a stalled instruction on the following cycle, like a real IF/ID.

module tb_fwd_hazard_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic              id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic              stall;
    logic [1:0]        fwd_a, fwd_b;
`ifdef FWD_HAZARD_STATS_EN
    logic [CNT_W-1:0]  stall_cnt, fwd_cnt;
`endif

    fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef FWD_HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: the list of things that entered EX, oldest first.
    // Last entry is in EX now, the one before it is in MEM.
    typedef struct { bit v; bit rw; bit mr; bit [REG_AW-1:0] rd; } slot_t;
    typedef struct { int due; bit [1:0] a; bit [1:0] b; int sc; int fc; } fexp_t;
    typedef struct { int due; bit s; } sexp_t;

    slot_t hist[$];
    fexp_t fq[$];
    sexp_t sq[$];
    bit    stalled_last;
    int    m_stall_cnt, m_fwd_cnt;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    function automatic bit writes(slot_t sl, bit [REG_AW-1:0] s);
        return sl.v && sl.rw && (sl.rd != 0) && (sl.rd == s);
    endfunction

    function automatic bit [1:0] pick(slot_t ex, slot_t mem, bit [REG_AW-1:0] s);
        if (writes(ex, s))  return 2'b10;
        if (writes(mem, s)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(int x);
        return (x >= CNT_MAX) ? x : x + 1;
    endfunction

    task automatic model_reset();
        slot_t empty;
        empty = '{v:1'b0, rw:1'b0, mr:1'b0, rd:'0};
        hist.delete();
        hist.push_back(empty);
        hist.push_back(empty);
        stalled_last = 1'b0;
        m_stall_cnt  = 0;
        m_fwd_cnt    = 0;
    endtask

    // One clock of stimulus; the model predicts this cycle's stall and the
    // selects that the DUT must present in the next cycle.
    task automatic issue(input bit r, input bit v, input bit [REG_AW-1:0] rs,
                         input bit [REG_AW-1:0] rt, input bit [REG_AW-1:0] rd,
                         input bit rw, input bit mr, input bit fl);
        slot_t ex, mem, nxt;
        bit lu, s, enter;
        bit [1:0] a, b;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;

        ex  = hist[hist.size()-1];
        mem = hist[hist.size()-2];
        lu  = v && ex.v && ex.mr && (ex.rd != 0) && (ex.rd == rs || ex.rd == rt);
        s   = lu && !fl && !stalled_last;
        sq.push_back('{due:cyc, s:s});

        if (r) begin
            model_reset();
            fq.push_back('{due:cyc+1, a:2'b00, b:2'b00, sc:0, fc:0});
        end else begin
            enter = v && !s && !fl;
            a = enter ? pick(ex, mem, rs) : 2'b00;
            b = enter ? pick(ex, mem, rt) : 2'b00;
            nxt = '{v:enter, rw:enter && rw, mr:enter && mr, rd:rd};
            hist.push_back(nxt);
            if (hist.size() > 3) void'(hist.pop_front());
            if (s) m_stall_cnt = sat_inc(m_stall_cnt);
            if (a != 0 || b != 0) m_fwd_cnt = sat_inc(m_fwd_cnt);
            stalled_last = s;
            fq.push_back('{due:cyc+1, a:a, b:b, sc:m_stall_cnt, fc:m_fwd_cnt});
        end
    endtask

    task automatic alu(input bit [REG_AW-1:0] rd, input bit [REG_AW-1:0] rs,
                       input bit [REG_AW-1:0] rt);
        issue(0, 1, rs, rt, rd, 1, 0, 0);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops expectations as their cycle comes due.
    always @(negedge clk) begin
        sexp_t se;
        fexp_t fe;
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            se = sq.pop_front();
            checks++;
            if (se.due != cyc) begin
                errors++;
                $display("FAIL stall_missed due=%0d now=%0d", se.due, cyc);
            end else if (stall !== se.s) begin
                errors++;
                $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, se.s);
            end
        end
        while (fq.size() > 0 && fq[0].due <= cyc) begin
            fe = fq.pop_front();
            checks++;
            if (fe.due != cyc) begin
                errors++;
                $display("FAIL fwd_missed due=%0d now=%0d", fe.due, cyc);
            end else begin
                if (fwd_a !== fe.a) begin
                    errors++;
                    $display("FAIL fwd_a cyc=%0d got=%b exp=%b", cyc, fwd_a, fe.a);
                end
                checks++;
                if (fwd_b !== fe.b) begin
                    errors++;
                    $display("FAIL fwd_b cyc=%0d got=%b exp=%b", cyc, fwd_b, fe.b);
                end
`ifdef FWD_HAZARD_STATS_EN
                checks++;
                if (stall_cnt !== CNT_W'(fe.sc)) begin
                    errors++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, fe.sc);
                end
                checks++;
                if (fwd_cnt !== CNT_W'(fe.fc)) begin
                    errors++;
                    $display("FAIL fwd_cnt cyc=%0d got=%0d exp=%0d", cyc, fwd_cnt, fe.fc);
                end
`endif
            end
        end
    end

    initial begin
        bit r, v, rw, mr, fl;
        bit [REG_AW-1:0] rs, rt, rd;
        model_reset();

        issue(1, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0);

        // back-to-back: add r3; sub r5,r3,r4
        alu(3, 1, 2); alu(5, 3, 4); nop(); nop();
        // distance two: add r3; nop; or r6,r3,r3
        alu(3, 1, 2); nop(); alu(6, 3, 3); nop(); nop();
        // double writer: add r3; add r3; and r7,r3,r1
        alu(3, 1, 2); alu(3, 4, 5); alu(7, 3, 1); nop(); nop();
        // load-use: lw r2; add r4,r2,r1 (held one cycle, then reissued)
        issue(0, 1, 1, 0, 2, 1, 1, 0); alu(4, 2, 1); alu(4, 2, 1); nop(); nop();
        // r0 never forwards
        alu(0, 1, 2); alu(1, 0, 0); nop(); nop();
        // load with flushed dependent: no stall
        issue(0, 1, 1, 0, 2, 1, 1, 0); issue(0, 1, 2, 2, 4, 1, 0, 1); nop(); nop();
        // reset during an active stall
        issue(0, 1, 1, 0, 2, 1, 1, 0); issue(1, 1, 2, 1, 4, 1, 0, 0);
        alu(4, 2, 1); alu(5, 4, 4); nop();

        // randomized traffic; a stalled instruction is reissued unchanged
        r = 0; v = 0; rs = 0; rt = 0; rd = 0; rw = 0; mr = 0; fl = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(stalled_last && !r)) begin
                v  = ($urandom_range(0, 99) < 85);
                rs = v ? REG_AW'($urandom_range(0, 7)) : '0;
                rt = v ? REG_AW'($urandom_range(0, 7)) : '0;
                rd = v ? REG_AW'($urandom_range(0, 7)) : '0;
                mr = v && ($urandom_range(0, 99) < 30);
                rw = v && (mr || ($urandom_range(0, 99) < 80));
            end
            fl = ($urandom_range(0, 99) < 10);
            r  = ($urandom_range(0, 99) < 2);
            issue(r, v, rs, rt, rd, rw, mr, fl);
        end
        nop(); nop();

        @(posedge clk);
        #2;
        @(negedge clk);
        #1;
        checks++;
        if (sq.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d pending exp=0", sq.size(), fq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
